// File: rtl/booth_sel_decoder.sv
// Rebuilds a two's-complement operand from serial radix-4 Booth select codes, LSB digit first.
// Latency: word valid the cycle after its last code; stalls on io_out_ready=0 with io_in_ready=0.
module booth_sel_decoder #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [3:0]       io_in_bits_sel,
  input  logic             io_flush,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits_value,
  output logic             io_out_bits_err
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {ACCUM, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] digit;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CW:0]      shamt;
  logic             err, err_nxt;
  logic             illegal;
  logic             in_fire, out_fire, last_digit;

  // Sign-extended digit value; anything other than one-hot or zero is illegal and adds nothing.
  always_comb begin
    digit   = '0;
    illegal = 1'b0;
    case (io_in_bits_sel)
      4'b0000: digit = '0;
      4'b0001: digit = '1;
      4'b0010: digit = WIDTH'(1);
      4'b0100: digit = {{(WIDTH-1){1'b1}}, 1'b0};
      4'b1000: digit = WIDTH'(2);
      default: illegal = 1'b1;
    endcase
  end

  assign io_in_ready       = (state == ACCUM);
  assign io_out_valid      = (state == DONE);
  assign io_out_bits_value = (state == DONE) ? acc : '0;
  assign io_out_bits_err   = (state == DONE) ? err : 1'b0;

  assign in_fire    = io_in_valid && io_in_ready;
  assign out_fire   = io_out_valid && io_out_ready;
  assign last_digit = (cnt == CW'(DIGITS - 1));
  assign shamt      = {cnt, 1'b0};

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    err_nxt   = err;
    case (state)
      ACCUM: begin
        if (in_fire) begin
          acc_nxt = acc + (digit << shamt);
          err_nxt = err | illegal;
          if (last_digit) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      DONE: begin
        if (out_fire) begin
          acc_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
    // Flush overrides any handshake in the same cycle.
    if (io_flush) begin
      state_nxt = ACCUM;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      err_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_booth_sel_decoder.sv
// Directed bench for booth_sel_decoder: 8-bit directed words plus a 64-bit Booth-encode round trip.
module tb_booth_sel_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        a_in_valid = 1'b0, a_in_ready, a_flush = 1'b0;
  logic [3:0]  a_sel = 4'b0000;
  logic        a_out_valid, a_out_ready = 1'b0, a_err;
  logic [7:0]  a_value;

  logic        b_in_valid = 1'b0, b_in_ready, b_flush = 1'b0;
  logic [3:0]  b_sel = 4'b0000;
  logic        b_out_valid, b_out_ready = 1'b0, b_err;
  logic [63:0] b_value;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  booth_sel_decoder #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset),
    .io_in_valid(a_in_valid), .io_in_ready(a_in_ready), .io_in_bits_sel(a_sel),
    .io_flush(a_flush),
    .io_out_valid(a_out_valid), .io_out_ready(a_out_ready),
    .io_out_bits_value(a_value), .io_out_bits_err(a_err)
  );

  booth_sel_decoder #(.WIDTH(64)) u_dut64 (
    .clock(clock), .reset(reset),
    .io_in_valid(b_in_valid), .io_in_ready(b_in_ready), .io_in_bits_sel(b_sel),
    .io_flush(b_flush),
    .io_out_valid(b_out_valid), .io_out_ready(b_out_ready),
    .io_out_bits_value(b_value), .io_out_bits_err(b_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent selector-generator model: window {x[2i+1], x[2i], x[2i-1]}, x[-1]=0.
  function automatic logic [3:0] enc(input logic [63:0] x, input int i);
    logic [64:0] xe;
    logic [2:0]  w;
    xe = {x, 1'b0};
    w  = xe[2*i+2 -: 3];
    case (w)
      3'b000, 3'b111: enc = 4'b0000;
      3'b001, 3'b010: enc = 4'b0010;
      3'b011:         enc = 4'b1000;
      3'b100:         enc = 4'b0100;
      default:        enc = 4'b0001;
    endcase
  endfunction

  // Codes packed with the first (least significant) digit in the low nibble.
  task automatic feed8(input logic [15:0] codes, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_in_ready"}, a_in_ready, 1);
      chk({tag, "_no_early_valid"}, a_out_valid, 0);
      a_in_valid = 1'b1;
      a_sel      = codes[4*i +: 4];
      tick();
    end
    a_in_valid = 1'b0;
    a_sel      = 4'b0000;
  endtask

  task automatic take8(input string tag, input logic [7:0] val, input logic e);
    chk({tag, "_out_valid"}, a_out_valid, 1);
    chk({tag, "_value"}, a_value, val);
    chk({tag, "_err"}, a_err, e);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk({tag, "_released"}, a_out_valid, 0);
  endtask

  initial begin
    logic [31:0] stream;
    logic [63:0] x;
    int          idx, k;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_value", a_value, 0);
    chk("rst_err", a_err, 0);
    chk("rst64_value", b_value, 0);
    reset = 1'b1;
    tick();

    // +1,+1,-1,-1 -> 1+4-16-64 = -75
    feed8(16'h1122, 4, "b5");
    take8("b5", 8'hB5, 1'b0);

    // Top +2 digit and top -2 digit, then back-to-back with out_ready held high
    feed8(16'h8001, 4, "x7f");
    take8("x7f", 8'h7F, 1'b0);
    stream      = {16'h4000, 16'h8001};
    idx         = 0;
    a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      chk("b2b_out_valid", a_out_valid, (cyc == 4 || cyc == 9) ? 1 : 0);
      chk("b2b_in_ready", a_in_ready, (cyc == 4 || cyc == 9) ? 0 : 1);
      if (cyc == 4) chk("b2b_word0", a_value, 8'h7F);
      if (cyc == 9) chk("b2b_word1", a_value, 8'h80);
      if (a_in_ready && idx < 8) begin
        a_in_valid = 1'b1;
        a_sel      = stream[4*idx +: 4];
        idx++;
      end else begin
        a_in_valid = (idx < 8);
        a_sel      = 4'b0000;
      end
      tick();
    end
    a_out_ready = 1'b0;
    a_in_valid  = 1'b0;
    chk("b2b_done", a_out_valid, 0);

    // Illegal 0011 in position 1 contributes 0: 1 + 16 = 0x11, err sticky; next word clean
    feed8(16'h0232, 4, "ill");
    take8("ill", 8'h11, 1'b1);
    feed8(16'h0000, 4, "zero");
    take8("zero", 8'h00, 1'b0);

    // Output backpressure with input still offered
    feed8(16'h1122, 4, "bp");
    a_in_valid = 1'b1;
    a_sel      = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      chk("bp_in_ready", a_in_ready, 0);
      chk("bp_value", a_value, 8'hB5);
      tick();
    end
    a_in_valid = 1'b0;
    take8("bp", 8'hB5, 1'b0);

    // Random input gaps
    k = 0;
    for (int c = 0; c < 200 && k < 4; c++) begin
      a_in_valid = 1'($urandom_range(0, 1));
      a_sel      = stream[4*k +: 4];
      if (a_in_valid && a_in_ready) k++;
      tick();
    end
    a_in_valid = 1'b0;
    chk("gap_accepted", k, 4);
    take8("gap", 8'h7F, 1'b0);

    // Flush after two codes; the code offered with the flush is discarded
    feed8(16'h0032, 2, "fl");
    a_flush    = 1'b1;
    a_in_valid = 1'b1;
    a_sel      = 4'b1000;
    tick();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    feed8(16'h1122, 4, "flb5");
    take8("flb5", 8'hB5, 1'b0);

    // Flush while DONE: word dropped, accumulator cleared
    feed8(16'h1122, 4, "fld");
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    chk("fld_dropped", a_out_valid, 0);
    tick();
    chk("fld_still_idle", a_out_valid, 0);
    chk("fld_in_ready", a_in_ready, 1);
    feed8(16'h8001, 4, "fld2");
    take8("fld2", 8'h7F, 1'b0);

    // Reset mid-word, including a pending illegal code
    feed8(16'h0023, 2, "rm");
    reset = 1'b0;
    tick();
    chk("rm_in_ready", a_in_ready, 1);
    chk("rm_out_valid", a_out_valid, 0);
    chk("rm_value", a_value, 0);
    chk("rm_err", a_err, 0);
    reset = 1'b1;
    feed8(16'h1122, 4, "rmb5");
    take8("rmb5", 8'hB5, 1'b0);

    // 64-bit round trip through the Booth encoder model
    for (int n = 0; n < 1500; n++) begin
      case (n)
        0:       x = 64'h0;
        1:       x = 64'hFFFF_FFFF_FFFF_FFFF;
        2:       x = 64'h8000_0000_0000_0000;
        3:       x = 64'h7FFF_FFFF_FFFF_FFFF;
        default: x = {$urandom, $urandom};
      endcase
      for (int i = 0; i < 32; i++) begin
        b_in_valid = 1'b1;
        b_sel      = enc(x, i);
        tick();
      end
      b_in_valid = 1'b0;
      chk("rt64_valid", b_out_valid, 1);
      chk("rt64_value", b_value, x);
      chk("rt64_err", b_err, 0);
      b_out_ready = 1'b1;
      tick();
      b_out_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
